// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared types and helpers for the sequential radix-4 Booth multiplier
// Revision : 1.0
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        D_ZERO = 3'd0,
        D_P1   = 3'd1,
        D_P2   = 3'd2,
        D_M1   = 3'd3,
        D_M2   = 3'd4
    } digit_t;

    // Extended operand width: always even and wide enough to hold a sign bit
    // above an unsigned N-bit value.
    function automatic int ext_width(input int n);
        return ((n % 2) == 0) ? n + 2 : n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_digit.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_digit
// Brief    : Radix-4 Booth triplet decoder and partial-product generator
// Revision : 1.0
// ============================================================================
module booth_r4_digit
    import booth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   i_triplet,
    input  logic [W-1:0] i_mcand,
    output logic [W-1:0] o_pp
);

    digit_t       w_digit;
    logic [W-1:0] w_mag;

    always_comb begin
        w_digit = D_ZERO;
        unique case (i_triplet)
            3'b001, 3'b010: w_digit = D_P1;
            3'b011:         w_digit = D_P2;
            3'b100:         w_digit = D_M2;
            3'b101, 3'b110: w_digit = D_M1;
            default:        w_digit = D_ZERO;
        endcase
    end

    always_comb begin
        w_mag = ((w_digit == D_P2) || (w_digit == D_M2)) ? (i_mcand << 1) : i_mcand;
        o_pp  = '0;
        unique case (w_digit)
            D_P1, D_P2: o_pp = w_mag;
            D_M1, D_M2: o_pp = ~w_mag + 1'b1;
            default:    o_pp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_mult
// Brief    : Sequential radix-4 Booth multiplier, one digit per clock,
//            signed/unsigned, start/ready/done handshake, registered product
// Revision : 1.0
// ============================================================================
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int E     = ext_width(N);
    localparam int STEPS = E / 2;
    localparam int c_aw  = E + N + 2;
    localparam int c_cw  = $clog2(STEPS + 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_capture;
    logic [c_cw-1:0]   r_count;
    logic [c_aw-1:0]   r_acc;
    logic [c_aw-1:0]   r_mcand;
    logic [E:0]        r_mplier;
    logic [2*N-1:0]    r_product;
    logic [c_aw-1:0]   w_pp;
    logic [c_aw-1:0]   w_a_ext;
    logic [E-1:0]      w_b_ext;

    assign w_a_ext = {{(c_aw - N){signed_mode & a[N-1]}}, a};
    assign w_b_ext = {{(E - N){signed_mode & b[N-1]}}, b};

    booth_r4_digit #(
        .W (c_aw)
    ) u_digit (
        .i_triplet (r_mplier[2:0]),
        .i_mcand   (r_mcand),
        .o_pp      (w_pp)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        done      = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_capture = 1'b1;
                    w_next    = RUN;
                end
            end
            RUN: begin
                if (r_count == c_cw'(STEPS)) w_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    w_capture = 1'b1;
                    w_next    = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Multiplicand walks left two places per digit while the multiplier walks
    // right, so the active triplet is always r_mplier[2:0] (bit 0 is b_ext[-1]).
    // The extra RUN cycle at count==STEPS transfers the finished sum to product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else if (w_capture) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= w_a_ext;
            r_mplier  <= {w_b_ext, 1'b0};
        end else if (r_state == RUN) begin
            if (r_count != c_cw'(STEPS)) begin
                r_acc    <= r_acc + w_pp;
                r_mcand  <= r_mcand << 2;
                r_mplier <= r_mplier >> 2;
                r_count  <= r_count + 1'b1;
            end else begin
                r_product <= r_acc[2*N-1:0];
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_mult
// Brief    : Self-checking bench for booth_seq_mult (N=8 and N=7 instances)
// Revision : 1.0
// ============================================================================
module tb_booth_seq_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [1:0] sm_v    = 2'b00;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];

    wire        ready8, done8, ready7, done7;
    wire [15:0] p8;
    wire [13:0] p7;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    booth_seq_mult #(.N(8)) dut8 (
        .clk (clk), .rst (rst), .start (start_v[0]), .signed_mode (sm_v[0]),
        .a (a_v[0]), .b (b_v[0]), .ready (ready8), .done (done8), .product (p8)
    );

    booth_seq_mult #(.N(7)) dut7 (
        .clk (clk), .rst (rst), .start (start_v[1]), .signed_mode (sm_v[1]),
        .a (a_v[1][6:0]), .b (b_v[1][6:0]), .ready (ready7), .done (done7), .product (p7)
    );

    function automatic logic get_done(int i);
        return (i == 0) ? done8 : done7;
    endfunction

    function automatic logic get_ready(int i);
        return (i == 0) ? ready8 : ready7;
    endfunction

    function automatic logic [15:0] get_prod(int i);
        return (i == 0) ? p8 : {2'b00, p7};
    endfunction

    // True product of two n-bit operands, truncated to 2n bits.
    function automatic logic [15:0] ref_prod(int n, logic [7:0] a, logic [7:0] b, logic sm);
        longint av, bv, p, lim;
        lim = longint'(1) << n;
        av  = longint'(a) & (lim - 1);
        bv  = longint'(b) & (lim - 1);
        if (sm && av >= lim / 2) av = av - lim;
        if (sm && bv >= lim / 2) bv = bv - lim;
        p = av * bv;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Interface-level model: an accepted start yields done LAT edges later.
    logic        m_ready [2] = '{1'b1, 1'b1};
    logic        m_done  [2] = '{1'b0, 1'b0};
    logic [15:0] m_prod  [2] = '{16'h0, 16'h0};
    logic [15:0] m_pend  [2] = '{16'h0, 16'h0};
    int          m_left  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ready[i] = 1'b1;
                m_done[i]  = 1'b0;
                m_prod[i]  = 16'h0;
                m_left[i]  = 0;
            end else if (m_ready[i] && start_v[i]) begin
                m_pend[i]  = ref_prod((i == 0) ? 8 : 7, a_v[i], b_v[i], sm_v[i]);
                m_left[i]  = (i == 0) ? 6 : 5;
                m_ready[i] = 1'b0;
                m_done[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_ready[i] = 1'b1;
                    m_done[i]  = 1'b1;
                    m_prod[i]  = m_pend[i];
                end
            end else begin
                m_ready[i] = 1'b1;
                m_done[i]  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready[%0d]", i), 32'(get_ready(i)), 32'(m_ready[i]));
            check($sformatf("done[%0d]", i), 32'(get_done(i)), 32'(m_done[i]));
            check($sformatf("product[%0d]", i), 32'(get_prod(i)), 32'(m_prod[i]));
        end
    end

    // Wait for done with a bound; returns edges since t0 (or large on timeout).
    task automatic wait_done(int i, int t0, output int lat);
        bit got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (get_done(i)) begin
                got = 1;
                break;
            end
        end
        lat = got ? (cyc - t0) : 999;
    endtask

    task automatic do_op(int i, logic sm, logic [7:0] a, logic [7:0] b,
                         logic use_exp, logic [15:0] exp);
        int t0, lat;
        start_v[i] = 1'b1; sm_v[i] = sm; a_v[i] = a; b_v[i] = b;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_v[i] = 1'b0; sm_v[i] = ~sm; a_v[i] = ~a; b_v[i] = ~b;
        check("accepted_ready", 32'(get_ready(i)), 32'd0);
        wait_done(i, t0, lat);
        check("latency", 32'(lat), (i == 0) ? 32'd6 : 32'd5);
        if (use_exp) check("literal_product", 32'(get_prod(i)), 32'(exp));
        else         check("random_product", 32'(get_prod(i)),
                           32'(ref_prod((i == 0) ? 8 : 7, a, b, sm)));
    endtask

    initial begin
        int t0, lat, ndone;
        logic [7:0] ra, rb;
        logic       rs;
        a_v[0] = 8'h0; b_v[0] = 8'h0; a_v[1] = 8'h0; b_v[1] = 8'h0;

        check("ref_m128sq", 32'(ref_prod(8, 8'h80, 8'h80, 1'b1)), 32'h4000);
        check("ref_255sq",  32'(ref_prod(8, 8'hFF, 8'hFF, 1'b0)), 32'hFE01);
        check("ref_7f_80",  32'(ref_prod(8, 8'h7F, 8'h80, 1'b1)), 32'hC080);
        check("ref_n7_m64", 32'(ref_prod(7, 8'h40, 8'h40, 1'b1)), 32'h1000);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready8), 32'd1);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_product", 32'(p8), 32'd0);

        do_op(0, 1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);
        @(negedge clk);
        do_op(0, 1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
        @(negedge clk);
        do_op(0, 1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001);
        @(negedge clk);
        do_op(0, 1'b1, 8'h7F, 8'h80, 1'b1, 16'hC080);
        do_op(0, 1'b1, 8'h03, 8'hFB, 1'b1, 16'hFFF1);

        // start during RUN must be ignored
        @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b1; a_v[0] = 8'h05; b_v[0] = 8'h06;
        @(posedge clk);
        #1 t0 = cyc; start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_v[0] = 1'b1; a_v[0] = 8'h11; b_v[0] = 8'h22;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        wait_done(0, t0, lat);
        check("ignore_latency", 32'(lat), 32'd6);
        check("ignore_product", 32'(p8), 32'h001E);

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b0; a_v[0] = 8'h12; b_v[0] = 8'h34;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready8), 32'd1);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_product", 32'(p8), 32'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op(0, 1'b1, 8'h0A, 8'h0B, 1'b1, 16'h006E);

        // N=7 instance
        @(negedge clk);
        do_op(1, 1'b1, 8'h40, 8'h40, 1'b1, 16'h1000);
        @(negedge clk);
        do_op(1, 1'b0, 8'h7F, 8'h7F, 1'b1, 16'h3F01);
        @(negedge clk);
        do_op(1, 1'b1, 8'h7F, 8'h7F, 1'b1, 16'h0001);
        for (int n = 0; n < 500; n++) begin
            ra = 8'($urandom_range(127));
            rb = 8'($urandom_range(127));
            rs = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) @(negedge clk);
            do_op(1, rs, ra, rb, 1'b0, 16'h0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
